// File: rtl/fp_norm_round_pkg.sv
// Shared fp32 definitions for the adder back end: field widths, sum bit positions, FSM states.
`default_nettype none
package fp_norm_round_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  // Rounding bit positions within the working sum, independent of mantissa width
  localparam int LSB_BIT = 3;
  localparam int G_BIT   = 2;
  localparam int R_BIT   = 1;
  localparam int S_BIT   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even and result packing for a normalised sum
// {hidden, mantissa, G, R, S}; also usable by a multiplier back end.
`default_nettype none
module fp_round_rne
  import fp_norm_round_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                 sign,
  input  logic [MAN_W+3:0]     sum,
  input  logic [EXP_W+1:0]     exp,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 ovf,
  output logic                 inexact
);

  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

  logic             up;
  logic [MAN_W+1:0] man_rnd;
  logic [MAN_W:0]   man;
  logic [XW-1:0]    exp_adj;
  logic [EXP_W-1:0] exp_field;

  always_comb begin
    up      = sum[G_BIT] & (sum[R_BIT] | sum[S_BIT] | sum[LSB_BIT]);
    man_rnd = {1'b0, sum[MAN_W+3:LSB_BIT]} + {{(MAN_W+1){1'b0}}, up};

    // Rounding 1.111..1 up carries out of the 24-bit significand
    if (man_rnd[MAN_W+1]) begin
      man     = man_rnd[MAN_W+1:1];
      exp_adj = exp + XW'(1);
    end else begin
      man     = man_rnd[MAN_W:0];
      exp_adj = exp;
    end

    exp_field = man[MAN_W] ? exp_adj[EXP_W-1:0] : '0;
    result    = {sign, exp_field, man[MAN_W-1:0]};
    ovf       = 1'b0;
    inexact   = sum[G_BIT] | sum[R_BIT] | sum[S_BIT];

    if (exp_adj >= EXP_MAX) begin
      result  = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf     = 1'b1;
      inexact = 1'b1;
    end else if (sum == '0) begin
      result = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_norm_round.sv
// fp32 adder post-add stage: carry fix-up, iterative one-bit-per-cycle normalisation,
// RNE rounding and packing, with valid/ready handshake and one beat in flight.
`default_nettype none
module fp_norm_round
  import fp_norm_round_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_W-1:0]     in_exp,
  input  logic [MAN_W+4:0]     in_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic                 out_ovf,
  output logic                 out_inexact
);

  localparam int SUM_W = MAN_W + 5;
  localparam int XW    = EXP_W + 2;
  localparam int CARRY = SUM_W - 1;
  localparam int HID   = SUM_W - 2;

  state_t               state, state_n;
  logic                 sign_r, sign_n;
  logic [XW-1:0]        exp_r, exp_n;
  logic [SUM_W-1:0]     sum_r, sum_n;
  logic [EXP_W+MAN_W:0] result_r, result_n;
  logic                 ovf_r, ovf_n;
  logic                 inexact_r, inexact_n;
  logic                 valid_r, valid_n;

  logic [EXP_W+MAN_W:0] rnd_result;
  logic                 rnd_ovf;
  logic                 rnd_inexact;

  fp_round_rne #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .sign    (sign_r),
    .sum     (sum_r[SUM_W-2:0]),
    .exp     (exp_r),
    .result  (rnd_result),
    .ovf     (rnd_ovf),
    .inexact (rnd_inexact)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sign_r    <= 1'b0;
      exp_r     <= '0;
      sum_r     <= '0;
      result_r  <= '0;
      ovf_r     <= 1'b0;
      inexact_r <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      state     <= state_n;
      sign_r    <= sign_n;
      exp_r     <= exp_n;
      sum_r     <= sum_n;
      result_r  <= result_n;
      ovf_r     <= ovf_n;
      inexact_r <= inexact_n;
      valid_r   <= valid_n;
    end
  end

  always_comb begin
    state_n   = state;
    sign_n    = sign_r;
    exp_n     = exp_r;
    sum_n     = sum_r;
    result_n  = result_r;
    ovf_n     = ovf_r;
    inexact_n = inexact_r;
    valid_n   = valid_r;

    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          sign_n  = in_sign;
          state_n = ST_NORM;
          // Carry out of the add: shift right once, folding R and S into the new sticky
          if (in_sum[CARRY]) begin
            sum_n = {1'b0, in_sum[SUM_W-1:2], in_sum[1] | in_sum[0]};
            exp_n = {2'b00, in_exp} + XW'(1);
          end else begin
            sum_n = in_sum;
            exp_n = {2'b00, in_exp};
          end
        end
      end
      ST_NORM: begin
        if (sum_r[HID] || (sum_r == '0) || (exp_r <= XW'(1))) begin
          state_n = ST_ROUND;
        end else begin
          sum_n = {sum_r[SUM_W-2:0], 1'b0};
          exp_n = exp_r - XW'(1);
        end
      end
      ST_ROUND: begin
        result_n  = rnd_result;
        ovf_n     = rnd_ovf;
        inexact_n = rnd_inexact;
        state_n   = ST_DONE;
      end
      ST_DONE: begin
        if (!valid_r) begin
          valid_n = 1'b1;
        end else if (out_ready) begin
          valid_n = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign in_ready    = (state == ST_IDLE);
  assign out_valid   = valid_r;
  assign out_result  = result_r;
  assign out_ovf     = ovf_r;
  assign out_inexact = inexact_r;

endmodule
`default_nettype wire
